// File: rtl/exec_stage_pkg.sv
// rtl/exec_stage_pkg.sv - shared pipeline constants: ALU op codes, EX FSM states, helpers
package exec_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_LUI   = 4'd8;
    localparam logic [3:0] ALU_MULTU = 4'd9;
    localparam logic [3:0] ALU_DIVU  = 4'd10;
    localparam logic [3:0] ALU_MFHI  = 4'd11;
    localparam logic [3:0] ALU_MFLO  = 4'd12;

    // Iterations of the shift-add multiplier / restoring divider
    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/exec_stage_md_unit.sv
// rtl/exec_stage_md_unit.sv - iterative unsigned shift-add multiplier / restoring divider
module md_unit
    import exec_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic        op,      // 0 = multiply, 1 = divide
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        r_run;
    logic [4:0]  r_count;
    logic        r_op;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_diff;

    // Multiply adds the multiplicand into HI when the multiplier LSB is set;
    // divide shifts the next dividend bit into the partial remainder. A zero
    // divisor naturally yields quotient all-ones and remainder = dividend.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
    assign w_div_shift = {r_hi, r_lo[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[31:0] - r_b;

    assign done = r_run && (r_count == 5'(MD_ITERS - 1));
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Load operands on start, then perform one iteration per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_count <= '0;
            r_op    <= 1'b0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (abort) begin
            r_run   <= 1'b0;
            r_count <= '0;
        end else if (start) begin
            r_run   <= 1'b1;
            r_count <= '0;
            r_op    <= op;
            r_b     <= b;
            r_hi    <= '0;
            r_lo    <= a;
        end else if (r_run) begin
            if (r_op) begin
                r_hi <= w_div_ge ? w_div_diff : w_div_shift[31:0];
                r_lo <= {r_lo[30:0], w_div_ge};
            end else begin
                {r_hi, r_lo} <= {w_mul_sum, r_lo[31:1]};
            end
            r_count <= r_count + 5'd1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: single-cycle ALU plus iterative MULTU/DIVU with HI/LO
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int MD_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm_ext,
    input  logic        alu_src,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    output logic        busy,
    output logic        out_valid,
    output logic        out_reg_write,
    output logic [4:0]  out_rd,
    output logic [31:0] result,
    output logic        zero
);

    ex_state_e   r_state;
    ex_state_e   w_next_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_b;
    logic [31:0] w_alu_result;
    logic        w_alu_we;
    logic        w_accept;
    logic        w_md_go;
    logic        w_md_commit;
    logic        w_md_done;
    logic [31:0] w_md_hi;
    logic [31:0] w_md_lo;

    assign w_b      = alu_src ? imm_ext : rt_data;
    assign w_accept = in_valid && !busy && !flush;
    assign w_md_go  = w_accept && is_md_op(alu_op) && (MD_EN != 0);

    md_unit u_md (
        .clk   (clk),
        .rst   (rst),
        .abort (flush),
        .start (w_md_go),
        .op    (alu_op == ALU_DIVU),
        .a     (rs_data),
        .b     (w_b),
        .done  (w_md_done),
        .hi    (w_md_hi),
        .lo    (w_md_lo)
    );

    // Single-cycle ALU result and register-write qualifier
    always_comb begin
        w_alu_result = '0;
        w_alu_we     = 1'b0;
        case (alu_op)
            ALU_ADD:  begin w_alu_result = rs_data + w_b;              w_alu_we = reg_write; end
            ALU_SUB:  begin w_alu_result = rs_data - w_b;              w_alu_we = reg_write; end
            ALU_AND:  begin w_alu_result = rs_data & w_b;              w_alu_we = reg_write; end
            ALU_OR:   begin w_alu_result = rs_data | w_b;              w_alu_we = reg_write; end
            ALU_XOR:  begin w_alu_result = rs_data ^ w_b;              w_alu_we = reg_write; end
            ALU_NOR:  begin w_alu_result = ~(rs_data | w_b);           w_alu_we = reg_write; end
            ALU_SLT:  begin w_alu_result = {31'd0, $signed(rs_data) < $signed(w_b)}; w_alu_we = reg_write; end
            ALU_SLTU: begin w_alu_result = {31'd0, rs_data < w_b};     w_alu_we = reg_write; end
            ALU_LUI:  begin w_alu_result = {w_b[15:0], 16'd0};         w_alu_we = reg_write; end
            ALU_MFHI: begin w_alu_result = r_hi;                       w_alu_we = reg_write; end
            ALU_MFLO: begin w_alu_result = r_lo;                       w_alu_we = reg_write; end
            default:  begin w_alu_result = '0;                         w_alu_we = 1'b0;      end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: a flush abandons RUN or DONE without committing HI/LO
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_md_go) w_next_state = ST_RUN;
            ST_RUN:  begin
                if (flush)          w_next_state = ST_IDLE;
                else if (w_md_done) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: stall upstream while the multiply/divide owns the stage
    always_comb begin
        busy        = (r_state != ST_IDLE);
        w_md_commit = (r_state == ST_DONE) && !flush;
    end

    // HI/LO update only when a multiply/divide completes unflushed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_md_commit) begin
            r_hi <= w_md_hi;
            r_lo <= w_md_lo;
        end
    end

    // EX/MEM register: every field clears in a cycle that carries no instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_rd        <= '0;
            result        <= '0;
            zero          <= 1'b0;
        end else if (w_md_commit) begin
            out_valid     <= 1'b1;
            out_reg_write <= 1'b0;
            out_rd        <= '0;
            result        <= '0;
            zero          <= 1'b1;
        end else if (w_accept && !w_md_go) begin
            out_valid     <= 1'b1;
            out_reg_write <= w_alu_we;
            out_rd        <= rd_addr;
            result        <= w_alu_result;
            zero          <= (w_alu_result == 32'd0);
        end else begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_rd        <= '0;
            result        <= '0;
            zero          <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - scoreboard bench for exec_stage
module tb_exec_stage;
    import exec_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] imm_ext = '0;
    logic        alu_src = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [4:0]  rd_addr = '0;
    logic        reg_write = 1'b0;
    logic        busy;
    logic        out_valid;
    logic        out_reg_write;
    logic [4:0]  out_rd;
    logic [31:0] result;
    logic        zero;

    int          total = 0;
    int          bad = 0;
    logic [38:0] exp_q[$];
    logic [38:0] mon_e;

    localparam logic [38:0] MD_PULSE = {1'b0, 5'd0, 32'd0, 1'b1};

    exec_stage #(.MD_EN(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .flush         (flush),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm_ext       (imm_ext),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_reg_write (out_reg_write),
        .out_rd        (out_rd),
        .result        (result),
        .zero          (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the stage presents a result
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got rd=%0d result=%0h expected no output", out_rd, result);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ex_mem{rw,rd,result,zero}", {out_reg_write, out_rd, result, zero}, mon_e);
                end
            end else begin
                chk("rw_gated", out_reg_write, 1'b0);
            end
        end
    end

    task automatic set_ins(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic src, input logic [4:0] rd);
        alu_op    = op;
        rs_data   = a;
        alu_src   = src;
        rt_data   = src ? 32'hDEAD_BEEF : b;
        imm_ext   = src ? b : 32'h1234_5678;
        rd_addr   = rd;
        reg_write = 1'b1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [4:0] rd, input logic we, input logic [31:0] res);
        set_ins(op, a, b, src, rd);
        in_valid = 1'b1;
        exp_q.push_back({we, rd, res, res == 32'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        set_ins(op, a, b, 1'b0, 5'd0);
        in_valid = 1'b1;
        exp_q.push_back(MD_PULSE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle("md_busy_cycles", 33);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_valid"},  out_valid, 1'b0);
        chk({name, "_rw"},     out_reg_write, 1'b0);
        chk({name, "_rd"},     out_rd, 5'd0);
        chk({name, "_result"}, result, 32'd0);
        chk({name, "_zero"},   zero, 1'b0);
        chk({name, "_busy"},   busy, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;

        alu(ALU_ADD,  32'h0000_0005, 32'hFFFF_FFFB, 1'b1, 5'd1, 1'b1, 32'h0000_0000);
        alu(ALU_SUB,  32'h0000_0003, 32'h0000_0005, 1'b0, 5'd2, 1'b1, 32'hFFFF_FFFE);
        alu(ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 5'd3, 1'b1, 32'h0000_0001);
        alu(ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 5'd4, 1'b1, 32'h00F0_000F);
        alu(ALU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 5'd5, 1'b1, 32'hFFF0_0FFF);
        alu(ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 5'd6, 1'b1, 32'hFF00_0FF0);
        alu(ALU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 5'd7, 1'b1, 32'h000F_F000);
        alu(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd8, 1'b1, 32'h0000_0001);
        alu(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd9, 1'b1, 32'h0000_0000);
        alu(ALU_LUI,  32'h0000_0000, 32'h0000_1234, 1'b1, 5'd10, 1'b1, 32'h1234_0000);
        alu(4'd13,    32'h0000_0001, 32'h0000_0002, 1'b0, 5'd11, 1'b0, 32'h0000_0000);
        alu(4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd12, 1'b0, 32'h0000_0000);

        md(ALU_MULTU, 32'h0001_0000, 32'h0001_0000);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd13, 1'b1, 32'h0000_0001);
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd14, 1'b1, 32'h0000_0000);

        md(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd15, 1'b1, 32'hFFFF_FFFE);
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd16, 1'b1, 32'h0000_0001);

        md(ALU_DIVU, 32'd7, 32'd0);
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd17, 1'b1, 32'hFFFF_FFFF);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd18, 1'b1, 32'h0000_0007);

        md(ALU_DIVU, 32'd100, 32'd7);
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd19, 1'b1, 32'd14);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd20, 1'b1, 32'd2);

        // in_valid held high across the whole busy window
        set_ins(ALU_MULTU, 32'd3, 32'd5, 1'b0, 5'd0);
        in_valid = 1'b1;
        exp_q.push_back(MD_PULSE);
        @(posedge clk); #1;
        set_ins(ALU_ADD, 32'd1, 32'd1, 1'b0, 5'd4);
        exp_q.push_back({1'b1, 5'd4, 32'd2, 1'b0});
        wait_idle("held_busy_cycles", 33);
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd21, 1'b1, 32'd15);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd22, 1'b1, 32'd0);

        // flush at iteration 10 of a divide
        set_ins(ALU_DIVU, 32'd100, 32'd7, 1'b0, 5'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_before_flush", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd23, 1'b1, 32'd15);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd24, 1'b1, 32'd0);

        // flush together with in_valid in IDLE drops the instruction
        set_ins(ALU_ADD, 32'd1, 32'd1, 1'b0, 5'd6);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk_outputs_zero("flush_idle");

        // reset in the middle of a multiply
        set_ins(ALU_MULTU, 32'd3, 32'd5, 1'b0, 5'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_outputs_zero("rst_mid_run");
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("busy_after_rst", busy, 1'b0);
        alu(ALU_MFLO, 32'h0, 32'h0, 1'b0, 5'd25, 1'b1, 32'd0);
        alu(ALU_MFHI, 32'h0, 32'h0, 1'b0, 5'd26, 1'b1, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
